pmod_led_sched: RTL and testbench

PMOD_LED_SCHED -- requirements
Module: pmod_led_sched

---
 rtl/pmod_led_sched.sv | 162 ++++++++++++++++
 tb/tb_pmod_led_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pmod_led_sched.sv
// -----------------------------------------------------------------------------
// pmod_led_sched
//
// Time-slot scheduler for PMOD LED banks. Up to three requesters each offer an
// 8-bit LED pattern. While idle, a round-robin arbiter grants one requester in
// the same cycle. The granted pattern owns the LEDs for SLOT_MS milliseconds
// and rotates left by one bit every STEP_MS milliseconds. The scheduler then
// returns to idle for at least one blank cycle before the next grant.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    [2:0]  request strobe per requester
//   req_pattern  [23:0] pattern per requester, requester i on [8i+7:8i]
//   req_ready    [2:0]  one-hot (or zero) grant, combinational, idle only
//   pmod_io      [pmod_num*8-1:0] active-low LED drive, every bank = ~pat
//   busy         high while a slot is being shown
//   owner        [1:0]  current owner index, 3 when idle
// -----------------------------------------------------------------------------
module pmod_led_sched #(
   parameter int frequency = 50_000_000,
   parameter int count_ms  = frequency / 1000,
   parameter int STEP_MS   = 200,
   parameter int SLOT_MS   = 1000,
   parameter int pmod_num  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              req_valid,
   input  logic [23:0]             req_pattern,
   output logic [2:0]              req_ready,
   output logic [pmod_num*8-1:0]   pmod_io,
   output logic                    busy,
   output logic [1:0]              owner
);

   localparam int STEP_CYC   = STEP_MS * count_ms;
   localparam int SLOT_STEPS = SLOT_MS / STEP_MS;
   localparam int STEP_W     = (STEP_CYC > 1)   ? $clog2(STEP_CYC)   : 1;
   localparam int SLOT_W     = (SLOT_STEPS > 1) ? $clog2(SLOT_STEPS) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_STEPS - 1);

   typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              ptr_q, ptr_d;
   logic [7:0]              pat_q, pat_d;
   logic [STEP_W-1:0]       step_q, step_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [1:0]              owner_q, owner_d;
   logic                    busy_q, busy_d;
   logic [pmod_num*8-1:0]   pmod_io_q, pmod_io_d;

   // Round-robin search order: ptr, ptr+1, ptr+2 (mod 3).
   logic [1:0] cand [3];
   logic       sel_found;
   logic [1:0] sel_idx;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cand
         logic [2:0] sum_w;
         assign sum_w     = {1'b0, ptr_q} + 3'(gi);
         assign cand[gi]  = (sum_w >= 3'd3) ? 2'(sum_w - 3'd3) : sum_w[1:0];
      end
   endgenerate

   // Walk from the lowest priority candidate upward so the earliest hit wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         if (req_valid[cand[k]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[k];
         end
      end
   end

   // Grant is only offered while idle; reset masks it immediately.
   always_comb begin
      req_ready = 3'b000;
      if (!rst && state_q == IDLE && sel_found) begin
         req_ready = 3'b001 << sel_idx;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pat_d   = pat_q;
      step_d  = step_q;
      slot_d  = slot_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if ((req_valid & req_ready) != 3'b000) begin
               state_d = SHOW;
               pat_d   = req_pattern[{sel_idx, 3'b000} +: 8];
               owner_d = sel_idx;
               ptr_d   = (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
               step_d  = '0;
               slot_d  = '0;
            end
         end
         SHOW: begin
            if (step_q == STEP_LAST) begin
               step_d = '0;
               pat_d  = {pat_q[6:0], pat_q[7]};
               if (slot_q == SLOT_LAST) begin
                  // Final rotation edge ends the slot.
                  state_d = IDLE;
                  owner_d = 2'd3;
                  slot_d  = '0;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHOW);
   end

   // Outputs are computed from the next state so they are registered yet
   // change on the same edge as the state.
   generate
      for (gi = 0; gi < pmod_num; gi++) begin : g_bank
         assign pmod_io_d[8*gi +: 8] = busy_d ? ~pat_d : 8'hFF;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         pat_q     <= 8'h00;
         step_q    <= '0;
         slot_q    <= '0;
         owner_q   <= 2'd3;
         busy_q    <= 1'b0;
         pmod_io_q <= '1;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         pat_q     <= pat_d;
         step_q    <= step_d;
         slot_q    <= slot_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         pmod_io_q <= pmod_io_d;
      end
   end

   assign pmod_io = pmod_io_q;
   assign busy    = busy_q;
   assign owner   = owner_q;

endmodule

// File: tb/tb_pmod_led_sched.sv
// -----------------------------------------------------------------------------
// tb_pmod_led_sched
//
// Scoreboard bench for pmod_led_sched with count_ms=4, STEP_MS=1, SLOT_MS=3
// (4-cycle steps, 12-cycle slots). Stimulus pushes the expected grant
// {index, pattern} for each accept; the monitor pops one entry per observed
// accept, then follows the slot cycle by cycle and checks the blank cycle.
// -----------------------------------------------------------------------------
module tb_pmod_led_sched;

   localparam int STEP_CYC = 4;
   localparam int SLOT_CYC = 12;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [23:0] req_pattern;
   logic [2:0]  req_ready;
   logic [23:0] pmod_io;
   logic        busy;
   logic [1:0]  owner;

   int tests = 0;
   int fails = 0;

   logic [9:0] sb [$];   // {index, pattern}

   pmod_led_sched #(
      .frequency (4000),
      .STEP_MS   (1),
      .SLOT_MS   (3),
      .pmod_num  (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_pattern (req_pattern),
      .req_ready   (req_ready),
      .pmod_io     (pmod_io),
      .busy        (busy),
      .owner       (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rotl(input logic [7:0] p, input int n);
      logic [7:0] r;
      r = p;
      repeat (n) r = {r[6:0], r[7]};
      return r;
   endfunction

   // Monitor: one transaction per accepted grant.
   initial begin : monitor
      logic [9:0]  e;
      logic [2:0]  exp_rdy;
      logic [23:0] exp_io;
      bit          skip;
      bit          aborted;
      skip = 1'b0;
      forever begin
         if (!skip) @(negedge clk);
         skip = 1'b0;
         if (!rst && (req_ready & req_valid) != 3'b000) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL grant: unexpected req_ready=%b req_valid=%b, none expected",
                        req_ready, req_valid);
               e = 10'h300;
            end else begin
               e = sb.pop_front();
               exp_rdy = 3'b001 << e[9:8];
               if (req_ready !== exp_rdy) begin
                  fails++;
                  $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
               end else begin
                  $display("[TB] grant to %0d pattern %h", e[9:8], e[7:0]);
               end
            end
            aborted = 1'b0;
            for (int c = 0; c < SLOT_CYC; c++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               exp_io = {3{~rotl(e[7:0], c / STEP_CYC)}};
               tests++;
               if (pmod_io !== exp_io || busy !== 1'b1 || owner !== e[9:8] || req_ready !== 3'b000) begin
                  fails++;
                  $display("FAIL slot cyc %0d: pmod_io=%h busy=%b owner=%0d ready=%b expected %h 1 %0d 000",
                           c, pmod_io, busy, owner, req_ready, exp_io, e[9:8]);
               end
            end
            if (!aborted) begin
               @(negedge clk);
               if (!rst) begin
                  tests++;
                  if (pmod_io !== 24'hFFFFFF || busy !== 1'b0 || owner !== 2'd3) begin
                     fails++;
                     $display("FAIL blank: pmod_io=%h busy=%b owner=%0d expected ffffff 0 3",
                              pmod_io, busy, owner);
                  end
                  skip = 1'b1;
               end
            end else begin
               $display("[TB] slot aborted by reset");
            end
         end
      end
   end

   // Drive valid from an idle cycle until n grants accepted, then let it finish.
   task automatic run_grants(input logic [2:0] v, input int n);
      req_valid = v;
      repeat (1 + (SLOT_CYC + 1) * (n - 1)) @(posedge clk);
      #1 req_valid = 3'b000;
      repeat (SLOT_CYC + 1) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      tests++;
      if (pmod_io !== 24'hFFFFFF || busy !== 1'b0 || owner !== 2'd3 || req_ready !== 3'b000) begin
         fails++;
         $display("FAIL %s: pmod_io=%h busy=%b owner=%0d ready=%b expected ffffff 0 3 000",
                  name, pmod_io, busy, owner, req_ready);
      end else begin
         $display("[TB] %s outputs ok", name);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst         = 1'b1;
      req_valid   = 3'b111;
      req_pattern = 24'h123456;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      req_valid = 3'b000;
      rst       = 1'b0;

      // Single request, pattern 01.
      req_pattern = {8'h00, 8'h00, 8'h01};
      sb.push_back({2'd0, 8'h01});
      run_grants(3'b001, 1);

      // ptr=1 after grant to 0: requester 2 before 0; pattern 00 as well.
      req_pattern = {8'h5A, 8'h77, 8'h00};
      sb.push_back({2'd2, 8'h5A});
      sb.push_back({2'd0, 8'h00});
      run_grants(3'b101, 2);

      // Request raised mid-slot waits for idle.
      req_pattern = {8'h00, 8'h96, 8'h11};
      sb.push_back({2'd0, 8'h11});
      sb.push_back({2'd1, 8'h96});
      req_valid = 3'b001;
      @(posedge clk);
      #1 req_valid = 3'b000;
      repeat (5) @(posedge clk);
      #1 req_valid = 3'b010;
      repeat (8) @(posedge clk);
      #1 req_valid = 3'b000;
      repeat (SLOT_CYC + 1) @(posedge clk);
      #1;

      // Pattern FF drives all LEDs on for the whole slot.
      req_pattern = {8'hFF, 8'h00, 8'h00};
      sb.push_back({2'd2, 8'hFF});
      run_grants(3'b100, 1);

      // All three requesting continuously.
      req_pattern = {8'hA5, 8'h3C, 8'h81};
      sb.push_back({2'd0, 8'h81});
      sb.push_back({2'd1, 8'h3C});
      sb.push_back({2'd2, 8'hA5});
      sb.push_back({2'd0, 8'h81});
      run_grants(3'b111, 4);

      // Reset pulse mid-slot; ptr must restart at 0 (otherwise 2 would win).
      req_pattern = {8'h0F, 8'hE7, 8'hF0};
      sb.push_back({2'd1, 8'hE7});
      req_valid = 3'b010;
      @(posedge clk);
      #1 req_valid = 3'b000;
      repeat (5) @(posedge clk);
      #1 req_valid = 3'b110;
      #1 rst = 1'b1;
      #1 check_reset_outputs("async reset");
      sb.push_back({2'd1, 8'hE7});
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1 req_valid = 3'b000;
      repeat (SLOT_CYC + 1) @(posedge clk);
      #1;

      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard: %0d grants still expected, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
